// File: rtl/board_pkg.sv
// Shared board-level constants and the key repeat FSM encoding.
// Also provides the counter-width helper used by the debounce and repeat timers.
package board_pkg;

  localparam int CLK_HZ         = 100_000_000;
  localparam int DEB_CYCLES_DEF = CLK_HZ / 100;
  localparam int REP_DELAY_DEF  = CLK_HZ / 2;
  localparam int REP_PERIOD_DEF = CLK_HZ / 10;

  typedef enum logic [1:0] {
    KEY_IDLE   = 2'd0,
    KEY_HELD   = 2'd1,
    KEY_REPEAT = 2'd2
  } key_state_e;

  // Bits needed to hold every value from 0 to max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stable-count debouncer and one-cycle rising-edge pulse
// for one raw push-button.
module btn_debounce
  import board_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic pulse
);

  localparam int CW = cnt_width(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          stable;
  logic          stable_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= btn;
      s2       <= s1;
      stable_q <= stable;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign level = stable;
  assign pulse = stable & ~stable_q;

endmodule

// File: rtl/key_input_ctrl.sv
// Board input conditioner: debounced go/address buttons, address step pulses
// with hold-to-auto-repeat, and the memory-view address counter.
module key_input_ctrl
  import board_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int REP_DELAY  = REP_DELAY_DEF,
  parameter int REP_PERIOD = REP_PERIOD_DEF,
  parameter int REPEAT_EN  = 1,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              addrI,
  input  logic              view_en,
  output logic              go_pulse,
  output logic              addr_pulse,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              go_level
);

  localparam int RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RW   = cnt_width(RMAX);
  // HELD counts 0..REP_DELAY so the first repeat lands REP_DELAY+1 cycles after the press pulse.
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REP_DELAY);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REP_PERIOD - 1);

  logic          addr_level;
  logic          addr_rise;
  key_state_e    state;
  key_state_e    state_d;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_go_deb (
    .clk   (clk),
    .rst   (rst),
    .btn   (go),
    .level (go_level),
    .pulse (go_pulse)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_addr_deb (
    .clk   (clk),
    .rst   (rst),
    .btn   (addrI),
    .level (addr_level),
    .pulse (addr_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= KEY_IDLE;
      rcnt  <= '0;
    end else begin
      state <= state_d;
      rcnt  <= rcnt_d;
    end
  end

  always_comb begin
    state_d    = state;
    rcnt_d     = rcnt;
    addr_pulse = 1'b0;
    case (state)
      KEY_IDLE: begin
        if (addr_rise) begin
          addr_pulse = 1'b1;
          rcnt_d     = '0;
          if (REPEAT_EN != 0) state_d = KEY_HELD;
        end
      end
      KEY_HELD: begin
        if (!addr_level) begin
          state_d = KEY_IDLE;
        end else if (rcnt == DELAY_LAST) begin
          addr_pulse = 1'b1;
          rcnt_d     = '0;
          state_d    = KEY_REPEAT;
        end else begin
          rcnt_d = rcnt + RW'(1);
        end
      end
      KEY_REPEAT: begin
        if (!addr_level) begin
          state_d = KEY_IDLE;
        end else if (rcnt == PERIOD_LAST) begin
          addr_pulse = 1'b1;
          rcnt_d     = '0;
        end else begin
          rcnt_d = rcnt + RW'(1);
        end
      end
      default: state_d = KEY_IDLE;
    endcase
  end

  // Leaving view mode clears the address even if a step arrives in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr <= '0;
    end else if (!view_en) begin
      mem_addr <= '0;
    end else if (addr_pulse) begin
      mem_addr <= mem_addr + ADDR_W'(1);
    end
  end

endmodule
